// File: rtl/hex_display_sequencer.sv
// Writes a latched packed hex value to NUM_DIGITS 7-segment PIO slaves, LSD first.
// Optional leading-zero blanking under macro HEX_SEQ_LZB_EN.
module hex_display_sequencer #(
    parameter int NUM_DIGITS = 6,
    parameter int WRITE_GAP  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [4*NUM_DIGITS-1:0] req_value,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_DIGITS-1:0]   hex_chipselect,
    output logic                    hex_write_n,
    output logic [1:0]              hex_address,
    output logic [31:0]             hex_writedata
);

    localparam int         VW     = 4 * NUM_DIGITS;
    localparam logic [2:0] D_LAST = 3'(NUM_DIGITS - 1);
    localparam logic [3:0] G_LAST = 4'(WRITE_GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              d_q, d_d;
    logic [3:0]              g_q, g_d;
    logic [VW-1:0]           val_q, val_d;
    logic [NUM_DIGITS-1:0]   cs_q, cs_d;
    logic                    wn_q, wn_d;
    logic [6:0]              wd_q, wd_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic [3:0]              nib;
    logic [6:0]              pat;

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

`ifdef HEX_SEQ_LZB_EN
    // Index of the most-significant nonzero nibble; 0 for an all-zero value.
    function automatic logic [2:0] msd(input logic [VW-1:0] v);
        msd = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) msd = 3'(i);
        end
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        g_d     = g_q;
        val_d   = val_q;
        cs_d    = '0;
        wn_d    = 1'b1;
        wd_d    = 7'd0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        nib     = 4'd0;
        pat     = 7'd0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    val_d   = req_value;
                    d_d     = 3'd0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (WRITE_GAP > 0) begin
                    g_d     = 4'd0;
                    state_d = S_GAP;
                end else if (d_q == D_LAST) begin
                    state_d = S_DONE;
                end else begin
                    d_d     = d_q + 3'd1;
                    state_d = S_WRITE;
                end
            end
            S_GAP: begin
                if (g_q == G_LAST) begin
                    if (d_q == D_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        d_d     = d_q + 3'd1;
                        state_d = S_WRITE;
                    end
                end else begin
                    g_d = g_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        nib = val_d[4*int'(d_d) +: 4];
        pat = seg(nib);
`ifdef HEX_SEQ_LZB_EN
        if (d_d > msd(val_d)) pat = 7'h7F;
`endif
        unique case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_WRITE: begin
                cs_d = NUM_DIGITS'(1) << d_d;
                wn_d = 1'b0;
                wd_d = pat;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            d_q     <= 3'd0;
            g_q     <= 4'd0;
            val_q   <= '0;
            cs_q    <= '0;
            wn_q    <= 1'b1;
            wd_q    <= 7'd0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            g_q     <= g_d;
            val_q   <= val_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign hex_chipselect = cs_q;
    assign hex_write_n    = wn_q;
    assign hex_address    = 2'd0;
    assign hex_writedata  = {25'd0, wd_q};

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Bench for hex_display_sequencer: three instances (6 digits/no gap, 6 digits/gap 2, 1 digit).
module tb_hex_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [23:0] req_value;

    logic [5:0]  cs0, csg;
    logic [0:0]  cs1;
    logic        wn0, wng, wn1, dn0, dng, dn1, rdy0, rdyg, rdy1, bsy0, bsyg, bsy1;
    logic [1:0]  ad0, adg, ad1;
    logic [31:0] wd0, wdg, wd1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    hex_display_sequencer #(.NUM_DIGITS(6), .WRITE_GAP(0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
        .req_value(req_value), .busy(bsy0), .done(dn0), .hex_chipselect(cs0),
        .hex_write_n(wn0), .hex_address(ad0), .hex_writedata(wd0));

    hex_display_sequencer #(.NUM_DIGITS(6), .WRITE_GAP(2)) ug (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdyg),
        .req_value(req_value), .busy(bsyg), .done(dng), .hex_chipselect(csg),
        .hex_write_n(wng), .hex_address(adg), .hex_writedata(wdg));

    hex_display_sequencer #(.NUM_DIGITS(1), .WRITE_GAP(0)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_value(req_value[3:0]), .busy(bsy1), .done(dn1), .hex_chipselect(cs1),
        .hex_write_n(wn1), .hex_address(ad1), .hex_writedata(wd1));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pattern a digit should carry, from the value and the blanking rule.
    function automatic logic [6:0] exp_seg(logic [31:0] v, int n, int k);
        logic [3:0] nib;
        int m;
        nib = v[4*k +: 4];
        m = 0;
        for (int i = 0; i < n; i++) if (v[4*i +: 4] != 4'd0) m = i;
`ifdef HEX_SEQ_LZB_EN
        if (k > m) return 7'h7F;
`endif
        return seg_tab[nib];
    endfunction

    // Expected bus/status in cycle t after an accept at cycle 0.
    task automatic chk_cyc(string tag, int t, int n, int g, logic [31:0] v,
                           logic [7:0] cs, logic wn, logic [31:0] wd,
                           logic dn, logic rdy, logic bsy);
        int p, last, k;
        logic [7:0]  ecs;
        logic        ewn;
        logic [31:0] ewd;
        p = 1 + g;
        last = 1 + n * p;
        ecs = 8'd0; ewn = 1'b1; ewd = 32'd0;
        if ((t - 1) % p == 0 && (t - 1) / p < n) begin
            k = (t - 1) / p;
            ecs = 8'(1) << k;
            ewn = 1'b0;
            ewd = {25'd0, exp_seg(v, n, k)};
        end
        chk($sformatf("%s t=%0d cs", tag, t), 32'(cs), 32'(ecs));
        chk($sformatf("%s t=%0d write_n", tag, t), 32'(wn), 32'(ewn));
        chk($sformatf("%s t=%0d wdata", tag, t), wd, ewd);
        chk($sformatf("%s t=%0d done", tag, t), 32'(dn), 32'(t == last));
        chk($sformatf("%s t=%0d ready", tag, t), 32'(rdy), 32'(t > last));
        chk($sformatf("%s t=%0d busy", tag, t), 32'(bsy), 32'(t <= last));
    endtask

    task automatic chk_idle(string tag, logic [7:0] cs, logic wn, logic [1:0] ad,
                            logic [31:0] wd, logic dn, logic rdy, logic bsy);
        chk({tag, " cs"}, 32'(cs), 32'd0);
        chk({tag, " write_n"}, 32'(wn), 32'd1);
        chk({tag, " addr"}, 32'(ad), 32'd0);
        chk({tag, " wdata"}, wd, 32'd0);
        chk({tag, " done"}, 32'(dn), 32'd0);
        chk({tag, " ready"}, 32'(rdy), 32'd1);
        chk({tag, " busy"}, 32'(bsy), 32'd0);
    endtask

    task automatic hyg(string tag, logic [7:0] cs, logic wn, logic [1:0] ad, logic [31:0] wd);
        chk({tag, " addr"}, 32'(ad), 32'd0);
        chk({tag, " wdata_hi"}, wd >> 7, 32'd0);
        chk({tag, " cs_onehot0"}, 32'($onehot0(cs)), 32'd1);
        chk({tag, " cs_without_write"}, 32'((cs != 8'd0) && wn), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int nw;
        logic seen_done;
        logic [23:0] v;

        reset = 1'b1;
        req_valid = 1'b0;
        req_value = 24'd0;
        do_reset();
        chk_idle("rst u0", 8'(cs0), wn0, ad0, wd0, dn0, rdy0, bsy0);
        chk_idle("rst ug", 8'(csg), wng, adg, wdg, dng, rdyg, bsyg);
        chk_idle("rst u1", 8'(cs1), wn1, ad1, wd1, dn1, rdy1, bsy1);

        // Basic sequence, gap timing and single-digit build on one accept.
        req_valid = 1'b1;
        req_value = 24'h123456;
        for (int t = 1; t <= 21; t++) begin
            @(negedge clk);
            chk_cyc("basic u0", t, 6, 0, 32'h123456, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            chk_cyc("gap ug", t, 6, 2, 32'h123456, 8'(csg), wng, wdg, dng, rdyg, bsyg);
            chk_cyc("one u1", t, 1, 0, 32'h6, 8'(cs1), wn1, wd1, dn1, rdy1, bsy1);
            req_valid = 1'b0;
        end

        // Backpressure: second request held while the first is in flight.
        do_reset();
        req_valid = 1'b1;
        req_value = 24'h123456;
        for (int t = 1; t <= 16; t++) begin
            @(negedge clk);
            if (t <= 8)
                chk_cyc("bp first", t, 6, 0, 32'h123456, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            else
                chk_cyc("bp second", t - 8, 6, 0, 32'hFFFFFF, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            req_valid = (t >= 2 && t <= 9);
            if (t >= 2) req_value = 24'hFFFFFF;
        end

        // Reset mid-operation, sampled at the edge ending cycle 3.
        do_reset();
        req_valid = 1'b1;
        req_value = 24'h123456;
        nw = 0;
        seen_done = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (t <= 3)
                chk_cyc("midrst", t, 6, 0, 32'h123456, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            if (t == 4)
                chk_idle("midrst after", 8'(cs0), wn0, ad0, wd0, dn0, rdy0, bsy0);
            if (!wn0 && cs0 != 6'd0) nw++;
            if (dn0) seen_done = 1'b1;
            req_valid = 1'b0;
            reset = (t == 3);
        end
        chk("midrst writes", 32'(nw), 32'd3);
        chk("midrst done_seen", 32'(seen_done), 32'd0);

        // Leading-zero handling.
        do_reset();
        req_valid = 1'b1;
        req_value = 24'h0000A0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            chk_cyc("lzb A0", t, 6, 0, 32'hA0, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            req_valid = 1'b0;
            if (t == 8) begin
                req_valid = 1'b1;
                req_value = 24'h000000;
            end
        end
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            chk_cyc("lzb zero", t, 6, 0, 32'h0, 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
            req_valid = 1'b0;
        end

        // Random values, back-to-back, against the model.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            v = 24'($urandom);
            req_valid = 1'b1;
            req_value = v;
            for (int t = 1; t <= 8; t++) begin
                @(negedge clk);
                chk_cyc($sformatf("rand%0d", r), t, 6, 0, 32'(v), 8'(cs0), wn0, wd0, dn0, rdy0, bsy0);
                req_valid = 1'b0;
            end
        end

        // Bus hygiene under random traffic.
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            hyg("hyg u0", 8'(cs0), wn0, ad0, wd0);
            hyg("hyg ug", 8'(csg), wng, adg, wdg);
            hyg("hyg u1", 8'(cs1), wn1, ad1, wd1);
            req_valid = ($urandom_range(0, 3) == 0);
            req_value = 24'($urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_sequencer.md
Name: hex_display_sequencer

Overview:
- Avalon-MM write-master controller that drives a bank of 7-segment hex PIO slaves. Each slave takes a 7-bit active-low pattern at address 0; its reset value is 127, which means all segments off.
- Accepts one packed hex value over a valid/ready handshake and converts each nibble to a segment pattern. It then writes the patterns to the per-digit PIO slaves one at a time, least-significant digit first.
- Sits between the accelerator status logic and the hex PIO slaves in the system interconnect.

Parameters:
- NUM_DIGITS, 6, number of hex PIO slaves / nibbles driven (1..8).
- WRITE_GAP, 0, idle cycles inserted after every write (0..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE state.
- req_value  in  4*NUM_DIGITS  packed nibbles; nibble i goes to digit i.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last write of a sequence.
- hex_chipselect  out  NUM_DIGITS  one-hot select; bit i selects PIO slave i.
- hex_write_n  out  1  active-low write strobe.
- hex_address  out  2  always 0.
- hex_writedata  out  32  {25'b0, pattern[6:0]}.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, on port reset; it is sampled on the rising edge of clk.
- Reset values: state IDLE, req_ready=1, busy=0, done=0, hex_chipselect=0, hex_write_n=1, hex_address=0, hex_writedata=0.
- States: IDLE, WRITE, GAP, DONE. Digit index register d counts 0..NUM_DIGITS-1; gap counter g counts 0..WRITE_GAP-1.
- IDLE:
  - req_ready=1.
  - When req_valid && req_ready at an edge: latch req_value, set d=0, go to WRITE.
  - Later changes on req_value are ignored until the next accept.
- WRITE (exactly one cycle):
  - hex_chipselect=(1<<d), hex_write_n=0, hex_writedata[6:0]=seg(nibble d).
  - Next state: GAP if WRITE_GAP>0.
  - Otherwise: WRITE with d+1 if d<NUM_DIGITS-1, else DONE.
- GAP:
  - All bus outputs idle (chipselect 0, write_n 1, writedata 0).
  - Stays for WRITE_GAP cycles, then goes to WRITE(d+1), or to DONE if d was the last digit.
- DONE: done=1 for one cycle, req_ready=0, then IDLE.
- Bus outputs are registered. chipselect and write_n assert only in WRITE, never in any other state.
- seg() encoding: active-low, bit0=a..bit6=g.
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex)
- Latency (accept edge = cycle 0):
  - Write k occurs in cycle 1+k*(1+WRITE_GAP).
  - done is high in cycle 1+NUM_DIGITS*(1+WRITE_GAP).
  - req_ready returns high the following cycle.
- req_valid while busy: ignored and not queued. The requester must hold req_valid until it sees req_ready.
- Reset mid-operation: the next edge forces IDLE with the reset values. Remaining digits are not written, done is not pulsed, and digits already written keep their new value in the PIO slaves.
- A single-digit configuration (NUM_DIGITS=1) is legal: one write, then DONE.

Optional Feature:
- Macro HEX_SEQ_LZB_EN (leading-zero blanking).
- Defined:
  - Compute m = index of the most-significant nonzero latched nibble; m=0 if the value is zero.
  - Digits d>m are written with pattern 7F (blank). Digit 0 always shows its seg() value.
  - Every digit is still written, so sequence timing is identical.
- Undefined: every digit is written with seg(nibble).

Test Plan:
- Basic sequence: NUM_DIGITS=6, WRITE_GAP=0, accept 0x123456 at cycle 0.
  - Required: writes in cycles 1..6 to cs bits 0..5 with data 02,12,19,30,24,79.
  - done=1 in cycle 7; req_ready=1 in cycle 8.
- Gap timing: WRITE_GAP=2, same value.
  - Required: writes in cycles 1,4,7,10,13,16, bus idle in between.
  - done in cycle 19; req_ready=1 in cycle 20.
- Backpressure: second req_valid with 0xFFFFFF held during cycles 2..9 of a G=0 run.
  - Required: ignored while busy; accepted at cycle 8; its writes carry 0E, data in cycles 9..14.
- Reset mid-op: assert reset for one edge at cycle 4 of a G=0 run.
  - Required: only digits 0..2 written; no done pulse.
  - The next cycle shows reset values with req_ready=1.
- Leading-zero blanking: value 0x0000A0, then 0x000000.
  - With HEX_SEQ_LZB_EN defined: data 40,08,7F,7F,7F,7F, then 40,7F,7F,7F,7F,7F.
  - Without the macro: 40,08,40,40,40,40, then all 40.
- Bus hygiene: random requests over 1000 cycles.
  - Required: hex_address is always 0 and hex_writedata[31:7] is always 0.
  - chipselect is never non-one-hot, and is never asserted while write_n=1.
